// File: rtl/peripheral_receiver_if.sv
// Two-channel receiver bus: 4-phase sender handshakes plus the FIFO consumer side.
interface peripheral_receiver_if #(
    parameter int DEPTH = 4
);
    logic                     send1;
    logic                     send2;
    logic [15:0]              indata1;
    logic [15:0]              indata2;
    logic                     ack1;
    logic                     ack2;
    logic                     rd_en;
    logic [15:0]              rd_data;
    logic                     rd_src;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    // Senders and consumer drive requests; the receiver answers.
    modport master (
        output send1, send2, indata1, indata2, rd_en,
        input  ack1, ack2, rd_data, rd_src, empty, full, count
    );

    modport slave (
        input  send1, send2, indata1, indata2, rd_en,
        output ack1, ack2, rd_data, rd_src, empty, full, count
    );
endinterface

// File: rtl/peripheral_receiver.sv
// Two asynchronous 4-phase senders merged into one show-ahead FIFO.
// Each channel is synchronized, runs an IDLE/REQ/ACK FSM, and a round-robin
// arbiter grants at most one FIFO write per cycle while the FIFO is not full.
module peripheral_receiver #(
    parameter int DEPTH = 4
) (
    input  logic                 clkCPU,
    input  logic                 rst,
    peripheral_receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    logic [1:0]    send_in;
    logic [1:0]    sync1;
    logic [1:0]    ssend;
    state_t        state [2];
    logic [1:0]    ack_q;
    logic          rr;          // 0: channel 1 has priority, 1: channel 2
    logic [1:0]    in_req;
    logic [1:0]    grant;
    logic          push;
    logic          pop;
    logic [16:0]   wentry;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          empty_q;
    logic          full_q;

    assign send_in = {bus.send2, bus.send1};

    // Two-flop synchronizers for the asynchronous send lines
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            sync1 <= '0;
            ssend <= '0;
        end else begin
            sync1 <= send_in;
            ssend <= sync1;
        end
    end

    // Round-robin arbitration; a lone requester wins regardless of pointer
    always_comb begin
        grant = '0;
        for (int i = 0; i < 2; i++) in_req[i] = (state[i] == REQ);
        if (!full_q) begin
            if (in_req[0] && (!in_req[1] || !rr)) grant[0] = 1'b1;
            else if (in_req[1])                   grant[1] = 1'b1;
        end
        push    = |grant;
        pop     = bus.rd_en && !empty_q;
        wentry  = grant[1] ? {1'b1, bus.indata2} : {1'b0, bus.indata1};
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Per-channel handshake FSMs with registered ack, plus round-robin pointer
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) state[i] <= IDLE;
            ack_q <= '0;
            rr    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    IDLE: if (ssend[i]) state[i] <= REQ;
                    REQ: if (grant[i]) begin
                        state[i] <= ACK;
                        ack_q[i] <= 1'b1;
                    end
                    ACK: if (!ssend[i]) begin
                        state[i] <= IDLE;
                        ack_q[i] <= 1'b0;
                    end
                    default: begin
                        state[i] <= IDLE;
                        ack_q[i] <= 1'b0;
                    end
                endcase
            end
            if (grant[0])      rr <= 1'b1;
            else if (grant[1]) rr <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since the head is masked when empty
    always_ff @(posedge clkCPU) begin
        if (!rst && push) mem[wptr] <= wentry;
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == CW'(DEPTH));
        end
    end

    assign bus.ack1    = ack_q[0];
    assign bus.ack2    = ack_q[1];
    assign bus.rd_data = empty_q ? 16'h0 : mem[rptr][15:0];
    assign bus.rd_src  = empty_q ? 1'b0  : mem[rptr][16];
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.count   = cnt;
endmodule

// File: tb/tb_peripheral_receiver.sv
// Bench for peripheral_receiver: directed scenarios plus a randomized run
// against a queue model of the FIFO driven by observed grant (ack rise) order.
module tb_peripheral_receiver;
    localparam int DEPTH = 4;

    logic clkCPU;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    peripheral_receiver_if #(.DEPTH(DEPTH)) bus ();

    peripheral_receiver #(.DEPTH(DEPTH)) dut (
        .clkCPU (clkCPU),
        .rst    (rst),
        .bus    (bus)
    );

    initial clkCPU = 1'b0;
    always #5 clkCPU = ~clkCPU;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clkCPU);
    endtask

    task automatic set_send(input int ch, input logic v, input logic [15:0] d);
        if (ch == 1) begin bus.send1 = v; bus.indata1 = d; end
        else         begin bus.send2 = v; bus.indata2 = d; end
    endtask

    function automatic logic ack_of(input int ch);
        return (ch == 1) ? bus.ack1 : bus.ack2;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.send1 = 0; bus.send2 = 0; bus.indata1 = 0; bus.indata2 = 0; bus.rd_en = 0;
        step(2);
        rst = 1'b0;
    endtask

    // Full handshake on one channel; ok=0 if ack never rose or never fell.
    task automatic xfer(input int ch, input logic [15:0] d, output bit ok);
        int n;
        ok = 1;
        set_send(ch, 1'b1, d);
        n = 0;
        while (ack_of(ch) !== 1'b1 && n < 50) begin step(1); n++; end
        if (n >= 50) ok = 0;
        set_send(ch, 1'b0, d);
        n = 0;
        while (ack_of(ch) !== 1'b0 && n < 50) begin step(1); n++; end
        if (n >= 50) ok = 0;
    endtask

    task automatic pop1();
        bus.rd_en = 1'b1;
        step(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.send1 = 0; bus.send2 = 0; bus.indata1 = 0; bus.indata2 = 0; bus.rd_en = 0;
        step(2);
        checks++;
        if ({bus.ack1, bus.ack2, bus.empty, bus.full, bus.rd_src} !== 5'b00100 ||
            bus.count !== 3'd0 || bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ack=%b%b empty=%b full=%b count=%0d data=%h src=%b, want ack=00 empty=1 full=0 count=0 data=0 src=0",
                     bus.ack1, bus.ack2, bus.empty, bus.full, bus.count, bus.rd_data, bus.rd_src);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        set_send(1, 1'b1, 16'd7);
        step(3);                       // after edge 2
        checks++;
        if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL single_early_ack: ack1=%b want 0", bus.ack1); end
        step(1);                       // after edge 3
        checks++;
        if (bus.ack1 !== 1'b1 || bus.empty !== 1'b0 || bus.rd_data !== 16'd7 || bus.rd_src !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack1=%b empty=%b data=%h src=%b, want 1 0 0007 0", bus.ack1, bus.empty, bus.rd_data, bus.rd_src);
        end
        step(1);                       // after edge 4; drop before edge 5
        set_send(1, 1'b0, 16'd7);
        step(2);                       // after edge 6
        checks++;
        if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL single_release_hold: ack1=%b want 1", bus.ack1); end
        step(1);                       // after edge 7
        checks++;
        if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL single_release: ack1=%b want 0", bus.ack1); end
        pop1();
        checks++;
        if (bus.empty !== 1'b1 || bus.rd_data !== 16'h0 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: empty=%b data=%h count=%0d, want 1 0000 0", bus.empty, bus.rd_data, bus.count);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        set_send(1, 1'b1, 16'h0011);
        set_send(2, 1'b1, 16'h0022);
        step(4);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.ack2 !== 1'b0 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL contention_first: ack1=%b ack2=%b count=%0d, want 1 0 1", bus.ack1, bus.ack2, bus.count);
        end
        step(1);
        checks++;
        if (bus.ack2 !== 1'b1 || bus.count !== 3'd2) begin
            errors++;
            $display("FAIL contention_second: ack2=%b count=%0d, want 1 2", bus.ack2, bus.count);
        end
        checks++;
        if (bus.rd_data !== 16'h0011 || bus.rd_src !== 1'b0) begin
            errors++;
            $display("FAIL contention_head1: data=%h src=%b, want 0011 0", bus.rd_data, bus.rd_src);
        end
        pop1();
        checks++;
        if (bus.rd_data !== 16'h0022 || bus.rd_src !== 1'b1) begin
            errors++;
            $display("FAIL contention_head2: data=%h src=%b, want 0022 1", bus.rd_data, bus.rd_src);
        end
        pop1();
        set_send(1, 1'b0, 16'h0011);
        set_send(2, 1'b0, 16'h0022);
        step(3);
    endtask

    task automatic test_full();
        bit ok;
        logic [15:0] exp_d [4];
        logic        exp_s [4];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            xfer(1, 16'h00A0 + 16'(i), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL full_fill_timeout: transfer %0d ok=0 want 1", i); end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL full_flag: full=%b count=%0d, want 1 4", bus.full, bus.count);
        end
        set_send(2, 1'b1, 16'h0055);
        step(6);
        checks++;
        if (bus.ack2 !== 1'b0) begin errors++; $display("FAIL full_block: ack2=%b want 0", bus.ack2); end
        pop1();
        checks++;
        if (bus.ack2 !== 1'b0 || bus.count !== 3'd3 || bus.full !== 1'b0 || bus.rd_data !== 16'h00A1) begin
            errors++;
            $display("FAIL full_pop: ack2=%b count=%0d full=%b data=%h, want 0 3 0 00a1", bus.ack2, bus.count, bus.full, bus.rd_data);
        end
        step(1);
        checks++;
        if (bus.ack2 !== 1'b1 || bus.count !== 3'd4 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL full_refill: ack2=%b count=%0d full=%b, want 1 4 1", bus.ack2, bus.count, bus.full);
        end
        set_send(2, 1'b0, 16'h0055);
        exp_d = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h0055};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.rd_data !== exp_d[i] || bus.rd_src !== exp_s[i]) begin
                errors++;
                $display("FAIL full_drain: entry %0d data=%h src=%b, want %h %b", i, bus.rd_data, bus.rd_src, exp_d[i], exp_s[i]);
            end
            pop1();
        end
        step(2);
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        for (int v = 1; v <= 10; v++) begin
            xfer(1, 16'(v), ok);
            checks++;
            if (!ok || bus.rd_data !== 16'(v) || bus.count !== 3'd1) begin
                errors++;
                $display("FAIL wrap_value: ok=%0d data=%0d count=%0d, want 1 %0d 1", ok, bus.rd_data, bus.count, v);
            end
            pop1();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_end: empty=%b count=%0d, want 1 0", bus.empty, bus.count);
        end
    endtask

    task automatic test_empty_pop();
        apply_reset();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rd_data !== 16'h0 || bus.rd_src !== 1'b0) begin
                errors++;
                $display("FAIL empty_pop: cycle %0d count=%0d empty=%b data=%h, want 0 1 0000", i, bus.count, bus.empty, bus.rd_data);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        xfer(2, 16'h0044, ok);
        set_send(1, 1'b1, 16'h0033);
        step(4);
        checks++;
        if (!ok || bus.ack1 !== 1'b1 || bus.count !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_setup: ok=%0d ack1=%b count=%0d, want 1 1 2", ok, bus.ack1, bus.count);
        end
        rst = 1'b1;
        bus.rd_en = 1'b1;
        step(1);
        checks++;
        if (bus.ack1 !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_clear: ack1=%b count=%0d empty=%b data=%h, want 0 0 1 0000", bus.ack1, bus.count, bus.empty, bus.rd_data);
        end
        rst = 1'b0;
        bus.rd_en = 1'b0;
        step(3);
        checks++;
        if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL rstmid_early: ack1=%b want 0", bus.ack1); end
        step(1);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.rd_data !== 16'h0033) begin
            errors++;
            $display("FAIL rstmid_recapture: ack1=%b data=%h, want 1 0033", bus.ack1, bus.rd_data);
        end
        set_send(1, 1'b0, 16'h0033);
        step(3);
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        int          phase [2];
        int          wait_c [2];
        int          hold [2];
        logic [15:0] dat [2];
        logic        prev_ack [2];
        logic        rd;
        int          pre;
        int          rises;
        bit          popd;
        bit          stop;
        logic [16:0] head;
        apply_reset();
        phase = '{0, 0}; wait_c = '{0, 0}; hold = '{0, 0};
        dat = '{16'h0, 16'h0}; prev_ack = '{1'b0, 1'b0};
        stop = 0;
        for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
            // Sender behaviour for each channel
            for (int c = 0; c < 2; c++) begin
                case (phase[c])
                    0: if ($urandom_range(0, 3) == 0) begin
                        dat[c] = 16'($urandom);
                        set_send(c + 1, 1'b1, dat[c]);
                        phase[c] = 1; wait_c[c] = 0;
                    end
                    1: if (ack_of(c + 1) === 1'b1) begin
                        phase[c] = 2; hold[c] = $urandom_range(0, 3);
                    end else if (++wait_c[c] > 200) begin
                        errors++; stop = 1;
                        $display("FAIL rand_ack_timeout: ch%0d ack=%b want 1 within 200 cycles", c + 1, ack_of(c + 1));
                    end
                    2: if (hold[c] == 0) begin
                        set_send(c + 1, 1'b0, dat[c]); phase[c] = 3; wait_c[c] = 0;
                    end else hold[c]--;
                    default: if (ack_of(c + 1) === 1'b0) phase[c] = 0;
                        else if (++wait_c[c] > 20) begin
                            errors++; stop = 1;
                            $display("FAIL rand_release_timeout: ch%0d ack=%b want 0", c + 1, ack_of(c + 1));
                        end
                endcase
            end
            rd = ($urandom_range(0, 1) == 1);
            bus.rd_en = rd;
            pre  = q.size();
            popd = rd && (pre > 0);
            step(1);
            if (popd) void'(q.pop_front());
            rises = 0;
            for (int c = 0; c < 2; c++) begin
                if (ack_of(c + 1) === 1'b1 && prev_ack[c] === 1'b0) begin
                    rises++;
                    checks++;
                    if (pre == DEPTH) begin
                        errors++;
                        $display("FAIL rand_write_when_full: ch%0d acked with %0d entries queued, want no grant", c + 1, pre);
                    end
                    q.push_back({1'(c), dat[c]});
                end
                prev_ack[c] = ack_of(c + 1);
            end
            checks++;
            if (rises > 1) begin errors++; $display("FAIL rand_double_grant: %0d grants in one cycle, want <=1", rises); end
            head = (q.size() > 0) ? q[0] : 17'h0;
            checks++;
            if (int'(bus.count) !== q.size() || bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) ||
                {bus.rd_src, bus.rd_data} !== head) begin
                errors++;
                $display("FAIL rand_state: cyc %0d count=%0d empty=%b full=%b head=%h, want count=%0d head=%h",
                         cyc, bus.count, bus.empty, bus.full, {bus.rd_src, bus.rd_data}, q.size(), head);
            end
        end
        bus.rd_en = 1'b0;
        set_send(1, 1'b0, 16'h0);
        set_send(2, 1'b0, 16'h0);
        step(4);
    endtask

    initial begin
        rst = 1'b1;
        bus.send1 = 0; bus.send2 = 0; bus.indata1 = 0; bus.indata2 = 0; bus.rd_en = 0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_wrap();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/peripheral_receiver.md
PERIPHERAL_RECEIVER -- requirements
Module: peripheral_receiver

Interface
REQ-001 SHALL have parameter: DEPTH, 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clkCPU  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: send1, send2  input  1  channel transfer request (4-phase).
REQ-005 SHALL have ports: indata1, indata2  input  16  channel data, stable while sendN=1.
REQ-006 SHALL have ports: ack1, ack2  output  1  channel acknowledge, registered.
REQ-007 SHALL have port: rd_en  input  1  consumer pop request.
REQ-008 SHALL have port: rd_data  output  16  FIFO head data (show-ahead).
REQ-009 SHALL have port: rd_src  output  1  FIFO head source: 0=channel 1, 1=channel 2.
REQ-010 SHALL have ports: empty, full  output  1  FIFO status, registered.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-012 SHALL pass send1/send2 through a 2-flop synchronizer each; FSMs use only synchronized send (ssendN).
REQ-013 SHALL run one FSM per channel, states IDLE, REQ, ACK; ackN = 1 exactly when state is ACK.
REQ-014 IDLE: ssendN=1 -> REQ; else stay.
REQ-015 REQ: on write grant, write {src, indataN} into FIFO and -> ACK; without grant stay in REQ, ackN held 0.
REQ-016 ACK: ssendN=0 -> IDLE; else stay (ackN held 1).
REQ-017 SHALL grant at most one FIFO write per cycle, and only when full=0.
REQ-018 Both channels in REQ, not full: round-robin grant; pointer starts at channel 1 after reset, moves to the other channel after each grant.
REQ-019 Single channel in REQ: granted regardless of round-robin pointer; pointer still moves past that channel.
REQ-020 Latency: sendN high sampled at edge 0 -> REQ after edge 2 -> write and ackN=1 after edge 3 (FIFO not full, no contention).
REQ-021 Release: sendN low sampled at edge k -> ackN=0 after edge k+2.
REQ-022 FIFO: circular, read/write pointers wrap modulo DEPTH; count increments on write, decrements on pop, unchanged when both occur.
REQ-023 Pop occurs on rd_en=1 with empty=0; rd_en with empty=1 SHALL be ignored (no pointer/count change).
REQ-024 Simultaneous pop and write when full=1: pop occurs, write not granted that cycle (channel stays REQ, granted next cycle).
REQ-025 rd_data/rd_src SHALL reflect the head entry whenever empty=0; SHALL be 0 when empty=1.
REQ-026 empty = (count==0), full = (count==DEPTH), updated same edge as count.
REQ-027 FIFO order SHALL equal grant order; no entry lost or duplicated within one handshake.

Reset
REQ-028 rst=1 at an edge SHALL force: both FSMs IDLE, ack1=ack2=0, synchronizer flops 0, pointers 0, count=0, empty=1, full=0, rd_data=0, rd_src=0, round-robin to channel 1.
REQ-029 rst SHALL override all other inputs in the same cycle, including mid-handshake and pending pops.
REQ-030 Sender still holding sendN=1 after reset SHALL be treated as a new transfer (re-captured after REQ-020 latency).

Verification
REQ-031 Single transfer: indata1=16'd7, send1=1 from edge 0 -> ack1=1 after edge 3, empty=0, rd_data=7, rd_src=0; send1=0 at edge 5 -> ack1=0 after edge 7.
REQ-032 Contention: send1 (data 16'h0011) and send2 (data 16'h0022) rise same cycle -> ch1 written first, ch2 one cycle later; pops yield 0x0011/src0 then 0x0022/src1.
REQ-033 Full backpressure, DEPTH=4: four transfers without popping -> full=1, count=4; fifth send2=1 -> ack2 stays 0; one rd_en -> next cycle ch2 written, ack2=1, count=4.
REQ-034 Wrap-around: 10 sequential transfers of values 1..10 with a pop after each -> rd_data sequence 1..10, empty=1 at end, count=0.
REQ-035 Empty pop: rd_en=1 for 3 cycles with empty=1 -> count=0, empty=1, rd_data=0 throughout.
REQ-036 Reset mid-operation: rst=1 while ack1=1 and count=2 -> next cycle ack1=0, count=0, empty=1; send1 still 1 -> re-captured, ack1=1 3 edges after rst falls.
